f_op_issuer: RTL

- Initiator-side controller for the single-operation FPU wrapper interface (`f_add` family).
- Accepts operand pairs from an upstream valid/ready stream and issues them to the FPU wrapper, respecting its `busy` signal.
- Buffers returned results in a credit-protected FIFO, because the wrapper has no backpressure, and presents them downstream on a valid/ready stream with per-result and sticky error reporting.

---
 rtl/f_issue_pkg.sv | 13 +
 rtl/f_result_fifo.sv | 61 ++++++
 rtl/f_op_issuer.sv | 104 ++++++++++
 3 files changed

// File: rtl/f_issue_pkg.sv
// Shared types and defaults for the FPU operation issuer.
// The result record is sized for the widest supported operand format.
package f_issue_pkg;

    localparam int F_ISSUE_FLEN = 64;
    localparam int F_ISSUE_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic                    error;
        logic [F_ISSUE_FLEN-1:0] data;
    } f_result_t;

endpackage

// File: rtl/f_result_fifo.sv
// Result buffer between the FPU wrapper return path and the downstream stream.
// Registered pointers; storage is written on the clock edge and read combinationally at the head.
module f_result_fifo
    import f_issue_pkg::*;
#(
    parameter int DEPTH = F_ISSUE_DEPTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  f_result_t                    din,
    input  logic                         pop,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output f_result_t                    head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    f_result_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/f_op_issuer.sv
// Issues operand pairs to a single-op FPU wrapper and buffers its results.
// Credits cover in-flight plus buffered results, so the no-backpressure return never overflows.
module f_op_issuer
    import f_issue_pkg::*;
#(
    parameter int FLEN  = F_ISSUE_FLEN,
    parameter int DEPTH = F_ISSUE_DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       arg_vld,
    output logic                       arg_rdy,
    input  logic [FLEN-1:0]            arg_a,
    input  logic [FLEN-1:0]            arg_b,
    output logic                       fu_up_valid,
    output logic [FLEN-1:0]            fu_a,
    output logic [FLEN-1:0]            fu_b,
    input  logic                       fu_busy,
    input  logic                       fu_down_valid,
    input  logic [FLEN-1:0]            fu_res,
    input  logic                       fu_error,
    output logic                       res_vld,
    input  logic                       res_rdy,
    output logic [FLEN-1:0]            res_data,
    output logic                       res_error,
    output logic [$clog2(DEPTH+1)-1:0] outstanding,
    output logic                       err_sticky,
    output logic                       spurious,
    input  logic                       err_clr
);

    localparam int CW = $clog2(DEPTH+1);

    logic [CW-1:0] fifo_count;
    logic [CW:0]   credit_sum;
    logic          credit_ok;
    logic          issue;
    logic          ret;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    f_result_t     wr_entry;
    f_result_t     head;

    assign credit_sum  = {1'b0, outstanding} + {1'b0, fifo_count};
    assign credit_ok   = credit_sum < (CW+1)'(DEPTH);
    assign arg_rdy     = !fu_busy && credit_ok;
    assign issue       = arg_vld && arg_rdy;
    assign fu_up_valid = issue;
    assign fu_a        = arg_a;
    assign fu_b        = arg_b;

    assign ret  = fu_down_valid && (outstanding != '0);
    assign push = ret && !fifo_full;
    assign pop  = res_vld && res_rdy;

    assign wr_entry.error = fu_error;
    assign wr_entry.data  = F_ISSUE_FLEN'(fu_res);

    f_result_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (wr_entry),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .head  (head)
    );

    assign res_vld   = !fifo_empty;
    assign res_data  = head.data[FLEN-1:0];
    assign res_error = head.error;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
            err_sticky  <= 1'b0;
            spurious    <= 1'b0;
        end else begin
            case ({issue, ret})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            // A new event in the clear cycle must not be lost.
            if (push && fu_error) begin
                err_sticky <= 1'b1;
            end else if (err_clr) begin
                err_sticky <= 1'b0;
            end
            if (fu_down_valid && (outstanding == '0)) begin
                spurious <= 1'b1;
            end else if (err_clr) begin
                spurious <= 1'b0;
            end
        end
    end

endmodule
